// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch PC unit: FSM encodings, default PC constants and
// the instruction/PC pair carried through the output buffer.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_word_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready holding register between fetch and decode.
module fetch_out_buf
    import fetch_pc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  fetch_word_t data,
    input  logic        ready,
    output logic        valid,
    output fetch_word_t word
);

    // Clear beats load so a word fetched alongside a redirect never reaches decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            word  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Architectural PC owner: issues one fetch at a time, forwards words to decode,
// and applies branch redirects with flush and stale-response dropping.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        b_valid,
    input  logic        b_taken,
    input  logic [31:0] b_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        flush,
    output logic        misaligned,
    output logic [31:0] misaligned_pc
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n, req_pc, req_pc_n, mis_pc_n;
    logic [1:0]   stale, stale_n;
    logic [2:0]   stale_sum;
    fetch_word_t  pend, pend_n, buf_data, out_word;
    logic         flush_n, mis_n, buf_clear, buf_load;
    logic         redirect, accept, resp_used;

    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        req_pc_n  = req_pc;
        stale_n   = stale;
        pend_n    = pend;
        flush_n   = 1'b0;
        mis_n     = misaligned;
        mis_pc_n  = misaligned_pc;
        buf_clear = 1'b0;
        buf_load  = 1'b0;
        buf_data  = pend;
        redirect  = b_valid && b_taken && (state != S_HALT);
        accept    = (state == S_REQ) && imem_req_ready;
        resp_used = imem_resp_valid && ((stale != 2'd0) || (state == S_WAIT));
        // Requests still owed a response after this cycle all become stale on redirect.
        stale_sum = {1'b0, stale} + {2'b0, state == S_WAIT} + {2'b0, accept}
                    - {2'b0, resp_used};

        if (redirect && !is_word_aligned(b_pc)) begin
            mis_n     = 1'b1;
            mis_pc_n  = b_pc;
            flush_n   = 1'b1;
            buf_clear = 1'b1;
            state_n   = S_HALT;
        end else if (redirect) begin
            flush_n   = 1'b1;
            pc_n      = b_pc;
            buf_clear = 1'b1;
            state_n   = S_REQ;
            stale_n   = stale_sum[2] ? 2'd3 : stale_sum[1:0];
        end else begin
            if (stale != 2'd0 && imem_resp_valid)
                stale_n = stale - 2'd1;
            case (state)
                S_REQ: begin
                    if (accept) begin
                        req_pc_n = pc;
                        pc_n     = pc + PC_STEP;
                        state_n  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid && stale == 2'd0) begin
                        if (!if_valid || if_ready) begin
                            buf_load = 1'b1;
                            buf_data = '{instr: imem_resp_data, pc: req_pc};
                            state_n  = S_REQ;
                        end else begin
                            pend_n  = '{instr: imem_resp_data, pc: req_pc};
                            state_n = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        buf_load = 1'b1;
                        state_n  = S_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            req_pc        <= RESET_PC;
            stale         <= 2'd0;
            pend          <= '0;
            flush         <= 1'b0;
            misaligned    <= 1'b0;
            misaligned_pc <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            req_pc        <= req_pc_n;
            stale         <= stale_n;
            pend          <= pend_n;
            flush         <= flush_n;
            misaligned    <= mis_n;
            misaligned_pc <= mis_pc_n;
        end
    end

    fetch_out_buf u_out_buf (
        .clk   (clk),
        .rst   (rst),
        .clear (buf_clear),
        .load  (buf_load),
        .data  (buf_data),
        .ready (if_ready),
        .valid (if_valid),
        .word  (out_word)
    );

    assign if_instr = out_word.instr;
    assign if_pc    = out_word.pc;

endmodule
